// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing / hazard controller for the 5-stage MIPS core: load-use stalls,
// MEM redirect flushes, syscall halt and mult/div busy sequencing. Optional macro: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_hilo_use,
    input  logic        ex_is_load,
    input  logic        ex_rf_wen,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_md_valid,
    input  logic        ex_md_is_mult,
    input  logic        mem_redirect,
    input  logic        wb_syscall,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_clr,
    output logic        id_ex_clr,
    output logic        ex_mem_clr,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic        halted,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy_q, md_busy_d;

    logic load_use;
    logic md_hold;
    logic stall;
    logic in_halt;

    always_comb begin
        in_halt  = (state_q == HALT);
        load_use = ex_is_load & ex_rf_wen & (ex_waddr != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_waddr)) | (id_uses_rt & (id_rt == ex_waddr)));
        // A md op in EX is younger than a redirecting branch in MEM, so it must not start.
        md_start = ex_md_valid & (state_q == RUN) & ~mem_redirect & ~in_halt;
        md_done  = md_busy_q & (cnt_q == '0);
        md_hold  = id_hilo_use & ((state_q == MD_WAIT) | md_start);
        stall    = load_use | md_hold;
    end

    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_clr  = 1'b0;
        ex_mem_clr = 1'b0;
        if (in_halt) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
        end else if (mem_redirect) begin
            if_id_clr  = 1'b1;
            id_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
        end else if (stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
        end
    end

    // The busy counter runs independently of the FSM so an op in flight finishes even after HALT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_busy_d = md_busy_q;
        if (md_busy_q) begin
            if (cnt_q == '0) begin
                md_busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (md_start) begin
            md_busy_d = 1'b1;
            cnt_d     = ex_md_is_mult ? MULT_CNT : DIV_CNT;
        end
        case (state_q)
            RUN:     if (md_start) state_d = MD_WAIT;
            MD_WAIT: if (md_done)  state_d = RUN;
            default: state_d = HALT;
        endcase
        if (wb_syscall) state_d = HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign md_busy = md_busy_q;
    assign halted  = in_halt;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall & ~mem_redirect & ~in_halt & (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (mem_redirect & ~in_halt & (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 16'h0000;
    assign perf_flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stall/flush/halt priorities and mult/div busy timing.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_waddr;
    logic        id_uses_rs, id_uses_rt, id_hilo_use;
    logic        ex_is_load, ex_rf_wen, ex_md_valid, ex_md_is_mult;
    logic        mem_redirect, wb_syscall;
    logic        pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr;
    logic        md_start, md_busy, md_done, halted;
    logic [15:0] perf_stall_cnt, perf_flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int busy_cycles;
    int done_pulses;

    pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hilo_use(id_hilo_use), .ex_is_load(ex_is_load), .ex_rf_wen(ex_rf_wen),
        .ex_waddr(ex_waddr), .ex_md_valid(ex_md_valid), .ex_md_is_mult(ex_md_is_mult),
        .mem_redirect(mem_redirect), .wb_syscall(wb_syscall),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
        .ex_mem_clr(ex_mem_clr), .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
        .halted(halted), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_waddr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo_use = 1'b0;
        ex_is_load = 1'b0; ex_rf_wen = 1'b0; ex_md_valid = 1'b0; ex_md_is_mult = 1'b0;
        mem_redirect = 1'b0; wb_syscall = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        // exp = {pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr}
        check(tag, {27'd0, pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr}, {27'd0, exp});
    endtask

    task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_stall"}, {16'd0, perf_stall_cnt}, exp_stall);
        check({tag, "_flush"}, {16'd0, perf_flush_cnt}, exp_flush);
`else
        check({tag, "_stall"}, {16'd0, perf_stall_cnt}, 32'd0);
        check({tag, "_flush"}, {16'd0, perf_flush_cnt}, 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        exp_stall = 0;
        exp_flush = 0;
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check_ctrl("rst_ctrl", 5'b11000);
        check_perf("rst_perf");
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Load-use on rs, then same with $0 destination, then on rt.
        ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_waddr = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1 check_ctrl("lu_rs", 5'b00010);
        tick(); exp_stall++;
        ex_waddr = 5'd0; id_rs = 5'd0;
        #1 check_ctrl("lu_zero", 5'b11000);
        tick();
        ex_waddr = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        #1 check_ctrl("lu_rt", 5'b00010);
        tick(); exp_stall++;
        ex_is_load = 1'b0;
        #1 check_ctrl("no_load", 5'b11000);
        clear_inputs();
        tick();
        check_perf("lu_perf");

        // Mult: 4 busy cycles, done on the last, HI/LO consumer stalled throughout.
        ex_md_valid = 1'b1; ex_md_is_mult = 1'b1;
        #1 check("mul_start", {31'd0, md_start}, 32'd1);
        check("mul_busy0", {31'd0, md_busy}, 32'd0);
        tick();
        ex_md_valid = 1'b0; id_hilo_use = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_md_valid = (i == 1);
            #1 check("mul_busy", {31'd0, md_busy}, 32'd1);
            check("mul_done", {31'd0, md_done}, (i == 3) ? 32'd1 : 32'd0);
            check("mul_nostart", {31'd0, md_start}, 32'd0);
            check_ctrl("mul_hold", 5'b00010);
            tick(); exp_stall++;
        end
        ex_md_valid = 1'b0;
        #1 check("mul_idle", {31'd0, md_busy}, 32'd0);
        check_ctrl("mul_release", 5'b11000);
        clear_inputs();
        tick();
        check_perf("mul_perf");

        // Div: busy exactly 32 cycles; a redirect at cycle 10 flushes but does not cancel.
        ex_md_valid = 1'b1; ex_md_is_mult = 1'b0;
        #1 check("div_start", {31'd0, md_start}, 32'd1);
        tick();
        clear_inputs();
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            mem_redirect = (i == 9);
            #1;
            if (i == 9) begin
                check_ctrl("div_redirect", 5'b11111);
                exp_flush++;
            end
            if (md_busy) busy_cycles++;
            if (md_done) done_pulses++;
            tick();
        end
        mem_redirect = 1'b0;
        check("div_busy_len", busy_cycles, 32'd32);
        check("div_done_cnt", done_pulses, 32'd1);

        // md op in EX alongside a redirect is killed.
        ex_md_valid = 1'b1; ex_md_is_mult = 1'b1; mem_redirect = 1'b1;
        #1 check("kill_start", {31'd0, md_start}, 32'd0);
        check_ctrl("kill_ctrl", 5'b11111);
        tick(); exp_flush++;
        clear_inputs();
        #1 check("kill_nobusy", {31'd0, md_busy}, 32'd0);

        // Redirect overrides a load-use stall.
        ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_waddr = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        mem_redirect = 1'b1;
        #1 check_ctrl("lu_redirect", 5'b11111);
        tick(); exp_flush++;
        clear_inputs();
        check_perf("lu_redir_perf");

        // Syscall halt: sticky, ignores redirect and md starts.
        wb_syscall = 1'b1;
        tick();
        wb_syscall = 1'b0;
        check("halt_set", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_redirect = (i == 5);
            ex_md_valid  = (i == 7);
            #1 check_ctrl("halt_ctrl", 5'b00010);
            if (i == 7) check("halt_nostart", {31'd0, md_start}, 32'd0);
            tick();
        end
        clear_inputs();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check_perf("halt_perf");
        do_reset();

        // Syscall while mult busy: op completes, done pulses once.
        ex_md_valid = 1'b1; ex_md_is_mult = 1'b1;
        tick();
        clear_inputs();
        wb_syscall = 1'b1;
        tick();
        wb_syscall = 1'b0;
        check("mdhalt_halted", {31'd0, halted}, 32'd1);
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (md_busy) busy_cycles++;
            if (md_done) done_pulses++;
            tick();
        end
        check("mdhalt_busy_rem", busy_cycles, 32'd3);
        check("mdhalt_done", done_pulses, 32'd1);
        do_reset();

        // Asynchronous reset in the middle of a divide.
        ex_md_valid = 1'b1; ex_md_is_mult = 1'b0;
        tick();
        clear_inputs();
        tick();
        check("async_pre", {31'd0, md_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_busy", {31'd0, md_busy}, 32'd0);
        check_ctrl("async_ctrl", 5'b11000);
        tick();
        rst_n = 1'b1;
        tick();
        check("async_after", {31'd0, md_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It generates the PC/IF_ID enables and the IF_ID/ID_EX/EX_MEM clear pulses; the ID_EX clear drives the ID_EX_Reg clr input. It detects load-use hazards, handles MEM-stage control redirects and syscall halt. It also sequences the multicycle mult/div unit with a busy counter and stalls HI/LO consumers while that unit is busy.

Parameters:
MULT_LAT, 4, mult busy cycles (>=1)
DIV_LAT, 32, div busy cycles (>=1)
CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_hilo_use  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
ex_is_load  input  1  EX instruction is a load
ex_rf_wen  input  1  EX instruction writes RF
ex_waddr  input  5  EX destination register
ex_md_valid  input  1  mult/div instruction is in EX this cycle
ex_md_is_mult  input  1  1 = mult, 0 = div (valid with ex_md_valid)
mem_redirect  input  1  taken branch/jump resolved in MEM
wb_syscall  input  1  syscall in WB
pc_en  output  1  PC update enable
if_id_en  output  1  IF_ID load enable
if_id_clr  output  1  IF_ID clear
id_ex_clr  output  1  ID_EX clear (bubble)
ex_mem_clr  output  1  EX_MEM clear
md_start  output  1  one-cycle start pulse to mult/div unit
md_busy  output  1  mult/div in progress (registered)
md_done  output  1  one-cycle pulse, last busy cycle
halted  output  1  core halted (registered, sticky)
perf_stall_cnt  output  16  stall cycles (see Optional Feature)
perf_flush_cnt  output  16  redirect flushes (see Optional Feature)

Behaviour:
- State: FSM {RUN, MD_WAIT, HALT} plus busy counter cnt[CNT_W-1:0].
- Reset (rst_n=0, async): state=RUN, cnt=0, md_busy=0, halted=0, perf counters=0.
- Outputs pc_en..ex_mem_clr, md_start and md_done are combinational from state and inputs.
- load_use = ex_is_load & ex_rf_wen & (ex_waddr!=0) & ((id_uses_rs & id_rs==ex_waddr) | (id_uses_rt & id_rt==ex_waddr)).
- md_hold = id_hilo_use & (state==MD_WAIT | md_start).
- stall = load_use | md_hold.
- Priority, highest first:
  - HALT: pc_en=0, if_id_en=0, id_ex_clr=1, if_id_clr=0, ex_mem_clr=0.
  - mem_redirect: pc_en=1, if_id_en=1, if_id_clr=1, id_ex_clr=1, ex_mem_clr=1. Any stall is overridden.
  - stall: pc_en=0, if_id_en=0, id_ex_clr=1; clears otherwise 0.
  - otherwise: pc_en=1, if_id_en=1, all clears 0.
- md_start = ex_md_valid & (state==RUN) & ~mem_redirect & ~halted.
  - The md op in EX is younger than the redirecting branch, so it is killed.
  - ex_md_valid while state==MD_WAIT is ignored; md_hold prevents it in practice.
- RUN -> MD_WAIT on md_start; cnt loads (ex_md_is_mult ? MULT_LAT : DIV_LAT)-1.
- MD_WAIT: cnt decrements each cycle. When cnt==0: md_done=1, next state RUN.
  - md_busy=1 for exactly LAT cycles after the start edge.
  - LAT=1: MD_WAIT lasts one cycle, with md_done asserted in it.
- A redirect during MD_WAIT does not cancel the op, which is older than the branch.
- wb_syscall=1 in any state -> HALT at the next edge; halted=1. HALT is left only via reset.
  - If MD_WAIT was active, cnt keeps counting; md_done still pulses once and md_busy falls.
- Reset mid-MD_WAIT aborts the op immediately; md_busy=0 asynchronously.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: perf_stall_cnt increments on each cycle with stall=1 and no redirect and not HALT; perf_flush_cnt increments on each mem_redirect cycle outside HALT. Both are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are built.

Test Plan:
- ex_is_load=1, ex_rf_wen=1, ex_waddr=8, id_rs=8, id_uses_rs=1 -> pc_en=0, if_id_en=0, id_ex_clr=1 for that cycle. Same stimulus with ex_waddr=0 -> no stall.
- ex_md_valid=1, ex_md_is_mult=1 in RUN -> md_start pulse; md_busy=1 for 4 cycles; md_done on 4th; id_hilo_use=1 stalls all 4 cycles and releases the next cycle.
- Div start (DIV_LAT=32) -> md_busy high exactly 32 cycles. A mem_redirect at cycle 10 -> flush outputs pulse, md_busy stays high.
- ex_md_valid=1 together with mem_redirect=1 -> md_start=0, state stays RUN, all three clears=1.
- load_use and mem_redirect in the same cycle -> pc_en=1, if_id_clr=1, id_ex_clr=1, ex_mem_clr=1. With the macro defined: flush_cnt +1, stall_cnt unchanged.
- wb_syscall=1 -> halted=1 next cycle, pc_en=0 held for 20 cycles. Drop rst_n for 1 cycle -> halted=0, pc_en=1.
